// File: rtl/sparse_mac_pkg.sv
// Shared types and default widths for the sparse dot-product accumulator.
package sparse_mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefSize  = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAccW  = 20;

endpackage

// File: rtl/sparse_mac_accum_prefix_popcount.sv
// Counts the set bits of a bitmap strictly below a given bit position.
module prefix_popcount #(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE-1:0]         bitmap_i,
  input  logic [$clog2(SIZE)-1:0] index_i,
  output logic [$clog2(SIZE)-1:0] count_o
);

  localparam int unsigned IdxW = $clog2(SIZE);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (i < 32'(index_i)) begin
        count_o = count_o + IdxW'(bitmap_i[i]);
      end
    end
  end

endmodule

// File: rtl/sparse_mac_accum.sv
// Sparse dot-product MAC fed by a priority-encoder match stream.
// Define SPARSE_MAC_SAT_EN to clamp each accumulate instead of wrapping.
module sparse_mac_accum
  import sparse_mac_pkg::*;
#(
  parameter int unsigned SIZE   = DefSize,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic [SIZE-1:0]          bmap1_i,
  input  logic [SIZE-1:0]          bmap2_i,
  input  logic [SIZE*DATA_W-1:0]   data1_i,
  input  logic [SIZE*DATA_W-1:0]   data2_i,
  input  logic                     valid_i,
  input  logic [$clog2(SIZE)-1:0]  match_addr_i,
  input  logic                     last_i,
  output logic                     ready_o,
  output logic                     result_valid_o,
  output logic [ACC_W-1:0]         result_o,
  output logic                     err_o
);

  localparam int unsigned IdxW  = $clog2(SIZE);
  localparam int unsigned ProdW = 2 * DATA_W;

  state_e                   state_q, state_d;
  logic [SIZE-1:0]          bmap1_q, bmap1_d, bmap2_q, bmap2_d;
  logic [SIZE*DATA_W-1:0]   data1_q, data1_d, data2_q, data2_d;
  logic signed [ProdW-1:0]  prod_q, prod_d;
  logic                     prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [ACC_W-1:0]         result_q, result_d;
  logic                     result_valid_q, result_valid_d;
  logic                     err_q, err_d;

  logic [IdxW-1:0]          cnt1, cnt2;
  logic signed [DATA_W-1:0] op_a, op_b;
  logic signed [ProdW-1:0]  product;
  logic                     beat_legal;
  logic [ACC_W:0]           sum;
  logic [ACC_W-1:0]         acc_next;

  prefix_popcount #(.SIZE(SIZE)) u_pop1 (
    .bitmap_i (bmap1_q),
    .index_i  (match_addr_i),
    .count_o  (cnt1)
  );

  prefix_popcount #(.SIZE(SIZE)) u_pop2 (
    .bitmap_i (bmap2_q),
    .index_i  (match_addr_i),
    .count_o  (cnt2)
  );

  assign op_a       = data1_q[32'(cnt1) * DATA_W +: DATA_W];
  assign op_b       = data2_q[32'(cnt2) * DATA_W +: DATA_W];
  assign product    = op_a * op_b;
  assign beat_legal = bmap1_q[match_addr_i] & bmap2_q[match_addr_i];

  // One extra bit exposes signed overflow: it shows as a mismatch of the top two bits.
  assign sum = {acc_q[ACC_W-1], acc_q} +
               {{(ACC_W + 1 - ProdW){prod_q[ProdW-1]}}, prod_q};

`ifdef SPARSE_MAC_SAT_EN
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d        = state_q;
    bmap1_d        = bmap1_q;
    bmap2_d        = bmap2_q;
    data1_d        = data1_q;
    data2_d        = data2_q;
    prod_d         = prod_q;
    prod_vld_d     = 1'b0;
    acc_d          = prod_vld_q ? acc_next : acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_d          = err_q;

    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          bmap1_d = bmap1_i;
          bmap2_d = bmap2_i;
          data1_d = data1_i;
          data2_d = data2_i;
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = ((bmap1_i & bmap2_i) == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (valid_i) begin
          if (beat_legal) begin
            prod_d     = product;
            prod_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (last_i) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        result_valid_d = 1'b1;
        result_d       = acc_q;
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      bmap1_q        <= '0;
      bmap2_q        <= '0;
      data1_q        <= '0;
      data2_q        <= '0;
      prod_q         <= '0;
      prod_vld_q     <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      bmap1_q        <= bmap1_d;
      bmap2_q        <= bmap2_d;
      data1_q        <= data1_d;
      data2_q        <= data2_d;
      prod_q         <= prod_d;
      prod_vld_q     <= prod_vld_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
    end
  end

  assign ready_o        = (state_q == StIdle);
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sparse_mac_accum.sv
// Directed bench for sparse_mac_accum: job table plus reset/protocol sequences.
module tb_sparse_mac_accum;

  localparam int unsigned SIZE   = 8;
  localparam int unsigned DATA_W = 8;

  logic                   clk;
  logic                   rst;
  logic                   load;
  logic [SIZE-1:0]        bmap1, bmap2;
  logic [SIZE*DATA_W-1:0] data1, data2;
  logic                   valid;
  logic [2:0]             addr;
  logic                   last;

  logic        ready, rvalid, err;
  logic [19:0] result;
  logic        ready16, rvalid16, err16;
  logic [15:0] result16;

  int nchecks = 0;
  int nerrors = 0;

  sparse_mac_accum #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(20)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_i         (load),
    .bmap1_i        (bmap1),
    .bmap2_i        (bmap2),
    .data1_i        (data1),
    .data2_i        (data2),
    .valid_i        (valid),
    .match_addr_i   (addr),
    .last_i         (last),
    .ready_o        (ready),
    .result_valid_o (rvalid),
    .result_o       (result),
    .err_o          (err)
  );

  sparse_mac_accum #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(16)) dut16 (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_i         (load),
    .bmap1_i        (bmap1),
    .bmap2_i        (bmap2),
    .data1_i        (data1),
    .data2_i        (data2),
    .valid_i        (valid),
    .match_addr_i   (addr),
    .last_i         (last),
    .ready_o        (ready16),
    .result_valid_o (rvalid16),
    .result_o       (result16),
    .err_o          (err16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [7:0]  mask;  // encoder beat positions, last on highest
    int          exp;
    int          exp16;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string name, input vec_t v, input bit busy_load);
    int hi;
    int cnt;
    check({name, " ready"}, int'(ready), 1);
    load  = 1'b1;
    bmap1 = v.b1;
    bmap2 = v.b2;
    data1 = v.d1;
    data2 = v.d2;
    tick();
    load = 1'b0;
    hi = -1;
    for (int i = 0; i < 8; i++) if (v.mask[i]) hi = i;
    for (int i = 0; i < 8; i++) begin
      if (v.mask[i]) begin
        if (busy_load) begin
          // Inputs change under a busy job; captured values must be used.
          load  = 1'b1;
          bmap1 = 8'h01;
          bmap2 = 8'h02;
          data1 = '1;
          data2 = '1;
        end
        valid = 1'b1;
        addr  = 3'(i);
        last  = (i == hi);
        tick();
        valid = 1'b0;
        last  = 1'b0;
      end
    end
    load = 1'b0;
    cnt = 0;
    while (!rvalid && cnt < 10) begin
      tick();
      cnt++;
    end
    check({name, " latency"}, cnt, (v.mask == 8'h00) ? 1 : 2);
    check({name, " result"}, int'($signed(result)), v.exp);
    check({name, " result16"}, int'($signed(result16)), v.exp16);
    check({name, " err"}, int'(err), int'(v.exp_err));
    tick();
    check({name, " pulse_width"}, int'(rvalid), 0);
    check({name, " result_held"}, int'($signed(result)), v.exp);
  endtask

  initial begin
    int pulses;
    vec_t dense;

    rst   = 1'b1;
    load  = 1'b0;
    bmap1 = '0;
    bmap2 = '0;
    data1 = '0;
    data2 = '0;
    valid = 1'b0;
    addr  = '0;
    last  = 1'b0;

    vecs[0] = '{8'hFF, 8'hFF, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101,
                8'hFF, 8, 8, 1'b0};
    vecs[1] = '{8'hA0, 8'h81, 64'h0000_0000_0000_0403, 64'h0000_0000_0000_FE0A,
                8'h80, -8, -8, 1'b0};
    vecs[2] = '{8'h0F, 8'hF0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                8'h00, 0, 0, 1'b0};
    vecs[3] = '{8'h01, 8'h05, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0706,
                8'h05, 30, 30, 1'b1};
    vecs[4] = '{8'h0F, 8'h0F, 64'h0000_0000_807F_FF02, 64'h0000_0000_80FF_FF03,
                8'h0F, 16264, 16264, 1'b0};
`ifdef SPARSE_MAC_SAT_EN
    vecs[5] = '{8'hFF, 8'hFF, 64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F,
                8'hFF, 129032, 32767, 1'b0};
`else
    vecs[5] = '{8'hFF, 8'hFF, 64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F,
                8'hFF, 129032, -2040, 1'b0};
`endif
    dense = vecs[0];

    #12;
    check("reset ready", int'(ready), 1);
    check("reset rvalid", int'(rvalid), 0);
    check("reset result", int'(result), 0);
    check("reset err", int'(err), 0);
    rst = 1'b0;
    tick();

    // valid_i in IDLE must not set err or start anything.
    valid = 1'b1;
    addr  = 3'd2;
    last  = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    last  = 1'b0;
    check("idle_valid err", int'(err), 0);
    check("idle_valid ready", int'(ready), 1);
    check("idle_valid rvalid", int'(rvalid), 0);

    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Back-to-back: load immediately after the pulse cycle, with busy loads ignored.
    run_job("busy_load", dense, 1'b1);
    run_job("back2back", vecs[1], 1'b0);

    // Reset after 3 of 8 beats aborts the job.
    load  = 1'b1;
    bmap1 = dense.b1;
    bmap2 = dense.b2;
    data1 = dense.d1;
    data2 = dense.d2;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      addr  = 3'(i);
      tick();
    end
    valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst ready", int'(ready), 1);
    check("midrst rvalid", int'(rvalid), 0);
    check("midrst result", int'(result), 0);
    check("midrst err", int'(err), 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rvalid) pulses++;
    end
    check("midrst no_pulse", pulses, 0);
    run_job("after_rst", dense, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
